bcd_counter: RTL
================

BCD_COUNTER -- requirements
Module: bcd_counter

Interface
REQ-001 Parameter DIGITS, default 3, number of BCD digits (1..8); count width W = 4*DIGITS.
REQ-002 Parameter WRAP, default 1: 1 = roll over at range ends, 0 = saturate at range ends.
REQ-003 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port clr  in  1  synchronous clear of count to zero.
REQ-006 Port load  in  1  synchronous load request.
REQ-007 Port load_val  in  W  BCD value to load; digit i = bits [4i+3:4i].
REQ-008 Port en  in  1  step request; one count step per cycle while high.
REQ-009 Port up  in  1  step direction: 1 = increment, 0 = decrement.
REQ-010 Port count  out  W  registered BCD count.
REQ-011 Port carry  out  1  registered one-cycle pulse on range-end event.
REQ-012 Port tc  out  1  combinational terminal count: count = all 9s when up=1; count = 0 when up=0.
REQ-013 Port load_err  out  1  registered one-cycle pulse on a rejected load.
REQ-014 Port ovf  out  1  sticky overflow flag (see Configuration).

Function
REQ-015 Per-cycle priority SHALL be clr > load > en; with none active, count holds.
REQ-016 clr=1 SHALL set count=0 next edge; carry=0, load_err=0 that cycle.
REQ-017 load=1 with every load_val digit <= 9 SHALL set count=load_val next edge.
REQ-018 load=1 with any load_val digit > 9 SHALL leave count unchanged and pulse load_err for one cycle.
REQ-019 en=1, up=1: digit 0 +1; a digit at 9 SHALL become 0 and carry +1 into the next digit; digits below 9 increment with no further propagation.
REQ-020 en=1, up=0: digit 0 -1; a digit at 0 SHALL become 9 and borrow from the next digit.
REQ-021 Increment from all 9s: WRAP=1 -> count=0; WRAP=0 -> count holds all 9s; carry pulses in both cases.
REQ-022 Decrement from 0: WRAP=1 -> count = all 9s; WRAP=0 -> count holds 0; carry pulses in both cases.
REQ-023 carry SHALL be high exactly the cycle after the range-end step, else low.
REQ-024 Step latency SHALL be one cycle: count reflects a step on the edge where en is sampled.
REQ-025 A direction change between cycles SHALL take effect on the next step with no lost or extra step.
REQ-026 count SHALL never hold a digit > 9 after reset.
REQ-027 tc SHALL follow count and up with no register delay.

Reset
REQ-028 rst_n=0 SHALL asynchronously force count=0, carry=0, load_err=0, ovf=0.
REQ-029 Reset SHALL take effect mid-step or mid-load; the first edge after release SHALL obey REQ-015.

Configuration
REQ-030 Macro BCD_COUNTER_STICKY_OVF_EN defined: ovf SHALL set on any carry pulse and hold until clr or reset.
REQ-031 Macro undefined: ovf SHALL be tied to 0 and no flag register SHALL exist; all other behaviour unchanged.

Verification (DIGITS=3)
REQ-032 WRAP=1, load 0x998, en=1, up=1 for 3 cycles -> count 0x999, 0x000, 0x001; carry high only the cycle count=0x000.
REQ-033 WRAP=0, load 0x001, en=1, up=0 for 3 cycles -> count 0x000, 0x000, 0x000; carry pulses on the second cycle and third cycle.
REQ-034 load 0x1A3 -> count unchanged, load_err one-cycle pulse; then load 0x190 -> count 0x190, load_err 0.
REQ-035 Same cycle: clr=1, load=1 (0x555), en=1 -> count 0x000; next: load=1, en=1 -> count 0x555.
REQ-036 count 0x099, en=1, up=1 -> 0x100; then up=0 -> 0x099, tc=0 throughout.
REQ-037 Sticky macro defined, WRAP=1: wrap 0x999 -> 0x000, ovf=1; rst_n pulse low mid-cycle -> count 0x000, ovf 0 immediately.

Source files
------------

// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - Multi-digit up/down BCD counter with load, clear, carry and terminal count
//
// Parameters:
//   DIGITS   number of BCD digits (1..8); count width W = 4*DIGITS
//   WRAP     1 = roll over at range ends, 0 = saturate at range ends
//
// Ports:
//   clk       in   1   clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   clr       in   1   synchronous clear (highest priority)
//   load      in   1   synchronous load request
//   load_val  in   W   BCD value to load; digit i = bits [4i+3:4i]
//   en        in   1   step request (lowest priority)
//   up        in   1   step direction, 1 = increment, 0 = decrement
//   count     out  W   registered BCD count
//   carry     out  1   registered pulse the cycle after a range-end step
//   tc        out  1   combinational terminal count for the current direction
//   load_err  out  1   registered pulse the cycle after a rejected load
//   ovf       out  1   sticky overflow flag
//
// Optional feature:
//   BCD_COUNTER_STICKY_OVF_EN  when defined, ovf is a sticky flag set by any
//   carry pulse and cleared by clr or reset; otherwise ovf is tied low.

module bcd_counter #(
    parameter int DIGITS = 3,
    parameter bit WRAP   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                en,
    input  logic                up,
    output logic [4*DIGITS-1:0] count,
    output logic                carry,
    output logic                tc,
    output logic                load_err,
    output logic                ovf
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

    logic [W-1:0] count_nxt;
    logic         carry_nxt;
    logic         load_err_nxt;
    logic         at_max;
    logic         at_min;

    // True when every digit of v is a legal BCD digit (0..9).
    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // Ripple increment: a 9 becomes 0 and passes the carry on; the first
    // digit below 9 absorbs it and stops propagation.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Ripple decrement: a 0 becomes 9 and borrows from the next digit.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign at_max = (count == ALL_NINES);
    assign at_min = (count == '0);

    // Terminal count looks at the direction currently requested, so it
    // flips immediately when up changes even though count does not.
    assign tc = up ? at_max : at_min;

    // Next-state selection: clr > load > en > hold.
    always_comb begin
        count_nxt    = count;
        carry_nxt    = 1'b0;
        load_err_nxt = 1'b0;
        if (clr) begin
            count_nxt = '0;
        end else if (load) begin
            if (bcd_valid(load_val)) begin
                count_nxt = load_val;
            end else begin
                // Rejected load swallows the cycle: count holds even if en is high.
                load_err_nxt = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (at_max) begin
                    carry_nxt = 1'b1;
                    count_nxt = WRAP ? '0 : ALL_NINES;
                end else begin
                    count_nxt = bcd_inc(count);
                end
            end else begin
                if (at_min) begin
                    carry_nxt = 1'b1;
                    count_nxt = WRAP ? ALL_NINES : '0;
                end else begin
                    count_nxt = bcd_dec(count);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            carry    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            count    <= count_nxt;
            carry    <= carry_nxt;
            load_err <= load_err_nxt;
        end
    end

`ifdef BCD_COUNTER_STICKY_OVF_EN
    // Set on the same edge that raises carry, so ovf and carry appear together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else if (carry_nxt) begin
            ovf <= 1'b1;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule
